// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: 8N1 serial transmitter fed by a small circular FIFO.
// Bytes are enqueued on each rising edge of load_data, then shifted out LSB first.
// Frames are sent back-to-back while the FIFO holds data.
module uart_fifo_tx #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 2
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic [7:0]       parallel_in,
  input  logic             load_data,
  input  logic             clear_overflow,
  output logic             tx_line,
  output logic             tx_busy,
  output logic             tx_idle,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               load_q, load_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]         fifo_mem_q [DEPTH];

  logic full, empty, load_edge, push, drop, pop, baud_end;
  logic [7:0] head;

  // Load edge detection and FIFO status, all from state registered before the edge
  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    load_edge = load_data & ~load_q;
    push      = load_edge & ~full;
    drop      = load_edge & full;
    load_d    = load_data;
    head      = fifo_mem_q[rd_ptr_q];
    baud_end  = (baud_cnt_q == BAUD_LAST);
  end

  // Transmit FSM: frame sequencing, bit timing and FIFO pop requests
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shreg_d    = head;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shreg_q[0];
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Next bit is taken from shreg[1] so the pin updates on the shift edge
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (!empty) begin
            // Chain straight into the next start bit with no idle gap
            pop     = 1'b1;
            shreg_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  // Control registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      load_q     <= 1'b1;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      load_q     <= load_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Data storage: FIFO array and shift register need no reset
  always_ff @(posedge sysclk) begin
    shreg_q <= shreg_d;
    if (push) fifo_mem_q[wr_ptr_q] <= parallel_in;
  end

  assign tx_line    = tx_q;
  assign tx_busy    = full;
  assign tx_idle    = (state_q == IDLE) && empty;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule
